// File: rtl/drive_pkg.sv
// Shared types and constants for the drive-command mux and its mode guard.
// Optional command sanitising is enabled by defining DRIVE_MUX_SANITIZE_EN.
package drive_pkg;

    localparam int unsigned CMD_W     = 4;
    localparam int unsigned CMD_FWD   = 0;
    localparam int unsigned CMD_BWD   = 1;
    localparam int unsigned CMD_LEFT  = 2;
    localparam int unsigned CMD_RIGHT = 3;

    localparam logic [1:0] FRAME_HDR = 2'b10;
    localparam logic [7:0] FRAME_RST = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STOP = 2'd1,
        RUN  = 2'd2
    } drive_state_e;

    // UART frame layout, MSB first
    typedef struct packed {
        logic [1:0]       hdr;
        logic             destroy;
        logic             place;
        logic [CMD_W-1:0] cmd;
    } frame_t;

    // Contradictory axis requests cancel each other
    function automatic logic [CMD_W-1:0] sanitize(input logic [CMD_W-1:0] c);
        logic [CMD_W-1:0] r;
        r = c;
        if (c[CMD_FWD] && c[CMD_BWD]) begin
            r[CMD_FWD] = 1'b0;
            r[CMD_BWD] = 1'b0;
        end
        if (c[CMD_LEFT] && c[CMD_RIGHT]) begin
            r[CMD_LEFT]  = 1'b0;
            r[CMD_RIGHT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/drive_mode_guard.sv
// Mode-select guard: one-hot check, IDLE/STOP/RUN sequencing and the stop
// interval enforced on every change of driving source.
module drive_mode_guard
    import drive_pkg::*;
#(
    parameter int unsigned N_SRC       = 3,
    parameter int unsigned STOP_CYCLES = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             power,
    input  logic [N_SRC-1:0] mode_sel,
    output drive_state_e     state,
    output logic [IDX_W-1:0] active_idx,
    output logic             switching,
    output logic             mode_err
);

    localparam int unsigned STOP_W = $clog2(STOP_CYCLES + 1);
    localparam logic [STOP_W-1:0] STOP_LOAD = STOP_W'(STOP_CYCLES);

    logic             sel_onehot_c;
    logic [IDX_W-1:0] sel_idx_c;
    logic             sel_ok_q;
    logic [IDX_W-1:0] sel_idx_q;
    logic [IDX_W-1:0] target;
    logic [STOP_W-1:0] stop_cnt;

    // Decode mode_sel; the result is registered before the FSM acts on it
    always_comb begin
        sel_onehot_c = (mode_sel != '0) && ((mode_sel & (mode_sel - N_SRC'(1))) == '0);
        sel_idx_c    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_sel[i]) sel_idx_c = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            active_idx <= '0;
            switching  <= 1'b0;
            mode_err   <= 1'b0;
            sel_ok_q   <= 1'b0;
            sel_idx_q  <= '0;
            target     <= '0;
            stop_cnt   <= '0;
        end else begin
            mode_err  <= !sel_onehot_c;
            sel_ok_q  <= sel_onehot_c;
            sel_idx_q <= sel_idx_c;

            if (!power || !sel_ok_q) begin
                state     <= IDLE;
                switching <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= STOP;
                        switching <= 1'b1;
                        stop_cnt  <= STOP_LOAD;
                        target    <= sel_idx_q;
                    end
                    STOP: begin
                        // A different request restarts the full stop interval
                        if (sel_idx_q != target) begin
                            stop_cnt <= STOP_LOAD;
                            target   <= sel_idx_q;
                        end else if (stop_cnt <= STOP_W'(1)) begin
                            state      <= RUN;
                            switching  <= 1'b0;
                            active_idx <= target;
                        end else begin
                            stop_cnt <= stop_cnt - STOP_W'(1);
                        end
                    end
                    RUN: begin
                        if (sel_idx_q != active_idx) begin
                            state     <= STOP;
                            switching <= 1'b1;
                            stop_cnt  <= STOP_LOAD;
                            target    <= sel_idx_q;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        switching <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/drive_cmd_mux.sv
// Drive-command source mux with safe-stop mode switching and UART frame offer.
// Define DRIVE_MUX_SANITIZE_EN to cancel contradictory command bits.
module drive_cmd_mux
    import drive_pkg::*;
#(
    parameter int unsigned N_SRC          = 3,
    parameter int unsigned STOP_CYCLES    = 4,
    parameter int unsigned REFRESH_CYCLES = 0
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       power,
    input  logic [N_SRC-1:0]           mode_sel,
    input  logic [CMD_W*N_SRC-1:0]     src_cmd,
    input  logic                       place_barrier,
    input  logic                       destroy_barrier,
    output logic [CMD_W-1:0]           cmd_out,
    output logic [$clog2(N_SRC)-1:0]   active_idx,
    output logic                       switching,
    output logic                       mode_err,
    output logic [7:0]                 frame_data,
    output logic                       frame_valid,
    input  logic                       frame_ready
);

    localparam int unsigned IDX_W    = $clog2(N_SRC);
    localparam int unsigned REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned REF_LAST = (REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1;

    drive_state_e     state;
    logic [CMD_W-1:0] sel_cmd_c;
    logic [CMD_W-1:0] cmd_filt_c;
    frame_t           frame_now_c;
    frame_t           frame_q;
    frame_t           last_q;
    logic [REF_W-1:0] refresh_cnt;
    logic             refresh_expired_c;

    drive_mode_guard #(
        .N_SRC       (N_SRC),
        .STOP_CYCLES (STOP_CYCLES),
        .IDX_W       (IDX_W)
    ) u_guard (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .power      (power),
        .mode_sel   (mode_sel),
        .state      (state),
        .active_idx (active_idx),
        .switching  (switching),
        .mode_err   (mode_err)
    );

    // Source select and optional sanitising
    always_comb begin
        sel_cmd_c = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (active_idx == IDX_W'(i)) sel_cmd_c = src_cmd[i*CMD_W +: CMD_W];
        end
`ifdef DRIVE_MUX_SANITIZE_EN
        cmd_filt_c = sanitize(sel_cmd_c);
`else
        cmd_filt_c = sel_cmd_c;
`endif
    end

    // Power is checked directly so a power drop zeroes the command on the next edge
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_out <= '0;
        end else if (state == RUN && power) begin
            cmd_out <= cmd_filt_c;
        end else begin
            cmd_out <= '0;
        end
    end

    always_comb begin
        frame_now_c.hdr     = FRAME_HDR;
        frame_now_c.destroy = destroy_barrier;
        frame_now_c.place   = place_barrier;
        frame_now_c.cmd     = cmd_out;
        refresh_expired_c   = (REFRESH_CYCLES != 0) && (refresh_cnt == REF_W'(REF_LAST));
    end

    // Frame offer: snapshot held until accepted; acceptance beats a new capture
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q     <= FRAME_RST;
            last_q      <= FRAME_RST;
            frame_valid <= 1'b0;
            refresh_cnt <= '0;
        end else if (frame_valid && frame_ready) begin
            last_q      <= frame_q;
            frame_valid <= 1'b0;
            refresh_cnt <= '0;
        end else begin
            if (REFRESH_CYCLES != 0 && !refresh_expired_c) begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end
            if (!frame_valid && ((frame_now_c != last_q) || refresh_expired_c)) begin
                frame_q     <= frame_now_c;
                frame_valid <= 1'b1;
            end
        end
    end

    assign frame_data = frame_q;

endmodule

// File: tb/tb_drive_cmd_mux.sv
// Directed bench for drive_cmd_mux: mode switching, stop interval, frame
// handshake scoreboard and periodic refresh on a second instance.
module tb_drive_cmd_mux;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        power;
    logic [2:0]  mode_sel;
    logic [11:0] src_cmd;
    logic        place_barrier;
    logic        destroy_barrier;
    logic        frame_ready;
    logic        frame_ready_r;

    logic [3:0]  cmd_out,     cmd_out_r;
    logic [1:0]  active_idx,  active_idx_r;
    logic        switching,   switching_r;
    logic        mode_err,    mode_err_r;
    logic [7:0]  frame_data,  frame_data_r;
    logic        frame_valid, frame_valid_r;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    drive_cmd_mux #(.N_SRC(3), .STOP_CYCLES(4), .REFRESH_CYCLES(0)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .power(power), .mode_sel(mode_sel),
        .src_cmd(src_cmd), .place_barrier(place_barrier), .destroy_barrier(destroy_barrier),
        .cmd_out(cmd_out), .active_idx(active_idx), .switching(switching), .mode_err(mode_err),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready)
    );

    drive_cmd_mux #(.N_SRC(3), .STOP_CYCLES(4), .REFRESH_CYCLES(8)) dut_r (
        .sys_clk(sys_clk), .rst_n(rst_n), .power(power), .mode_sel(mode_sel),
        .src_cmd(src_cmd), .place_barrier(place_barrier), .destroy_barrier(destroy_barrier),
        .cmd_out(cmd_out_r), .active_idx(active_idx_r), .switching(switching_r), .mode_err(mode_err_r),
        .frame_data(frame_data_r), .frame_valid(frame_valid_r), .frame_ready(frame_ready_r)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_src(input int i, input logic [3:0] c);
        src_cmd[i*4 +: 4] = c;
    endtask

    // Switching is expected high on cycles lo..hi after the drive point
    task automatic check_switch(input string tag, input int n, input int lo, input int hi,
                                input logic [3:0] prev_cmd, input logic [3:0] new_cmd,
                                input logic [1:0] prev_idx, input logic [1:0] new_idx);
        for (int i = 1; i <= n; i++) begin
            step(1);
            check($sformatf("%s_sw%0d", tag, i), 8'(switching), 8'(i >= lo && i <= hi));
            check($sformatf("%s_cmd%0d", tag, i), 8'(cmd_out),
                  8'((i <= lo) ? prev_cmd : ((i >= hi + 2) ? new_cmd : 4'b0000)));
            check($sformatf("%s_idx%0d", tag, i), 8'(active_idx),
                  8'((i >= hi + 1) ? new_idx : prev_idx));
        end
    endtask

    // Scoreboard: every accepted frame of the main instance is popped and compared
    always @(negedge sys_clk) begin
        #1;
        if (rst_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) check("frame_unexpected", 8'(exp_q.size()), 8'd1);
            else check("frame", frame_data, exp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0; power = 1'b0; mode_sel = '0; src_cmd = '0;
        place_barrier = 1'b0; destroy_barrier = 1'b0;
        frame_ready = 1'b0; frame_ready_r = 1'b1;
        step(2);
        check("rst_cmd", 8'(cmd_out), 8'h00);
        check("rst_idx", 8'(active_idx), 8'h00);
        check("rst_sw", 8'(switching), 8'h00);
        check("rst_err", 8'(mode_err), 8'h00);
        check("rst_fdata", frame_data, 8'h80);
        check("rst_fvalid", 8'(frame_valid), 8'h00);
        rst_n = 1'b1;
        step(1);
        check("err_zero_sel", 8'(mode_err), 8'h01);

        // Power up on source 0
        exp_q.push_back(8'h81);
        power = 1'b1; mode_sel = 3'b001; set_src(0, 4'b0001);
        check_switch("start", 7, 2, 5, 4'b0000, 4'b0001, 2'd0, 2'd0);
        step(1);
        check("f1_valid", 8'(frame_valid), 8'h01);
        check("f1_data", frame_data, 8'h81);

        // Frame frozen while ready is low and the command changes twice
        set_src(0, 4'b0101);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (i == 1) set_src(0, 4'b1001);
            check($sformatf("frozen_v%0d", i), 8'(frame_valid), 8'h01);
            check($sformatf("frozen_d%0d", i), frame_data, 8'h81);
        end
        check("cmd_latest", 8'(cmd_out), 8'h09);
        exp_q.push_back(8'h89);
        frame_ready = 1'b1;
        step(1);
        check("acc_clear", 8'(frame_valid), 8'h00);
        step(1);
        check("reoffer_v", 8'(frame_valid), 8'h01);
        check("reoffer_d", frame_data, 8'h89);

        // Switch to source 2
        step(2);
        exp_q.push_back(8'h80); exp_q.push_back(8'h84);
        mode_sel = 3'b100; set_src(2, 4'b0100);
        check_switch("sw2", 7, 2, 5, 4'b1001, 4'b0100, 2'd0, 2'd2);

        // Retarget during STOP restarts the interval
        exp_q.push_back(8'h80); exp_q.push_back(8'h88);
        mode_sel = 3'b010; set_src(1, 4'b0010);
        step(1);
        check("rt_sw1", 8'(switching), 8'h00);
        check("rt_cmd1", 8'(cmd_out), 8'h04);
        step(1);
        check("rt_sw2", 8'(switching), 8'h01);
        check("rt_cmd2", 8'(cmd_out), 8'h04);
        step(1);
        check("rt_sw3", 8'(switching), 8'h01);
        check("rt_cmd3", 8'(cmd_out), 8'h00);
        mode_sel = 3'b001; set_src(0, 4'b1000);
        check_switch("retarget", 7, 1, 5, 4'b0000, 4'b1000, 2'd2, 2'd0);

        // Multi-hot select forces IDLE
        exp_q.push_back(8'h80);
        mode_sel = 3'b011;
        step(1);
        check("err_multi", 8'(mode_err), 8'h01);
        step(2);
        check("err_cmd", 8'(cmd_out), 8'h00);
        check("err_sw", 8'(switching), 8'h00);
        check("err_idx_kept", 8'(active_idx), 8'h00);
        exp_q.push_back(8'h82);
        mode_sel = 3'b010;
        check_switch("restore", 7, 2, 5, 4'b0000, 4'b0010, 2'd0, 2'd1);
        check("err_clear", 8'(mode_err), 8'h00);

        // Contradictory commands
`ifdef DRIVE_MUX_SANITIZE_EN
        exp_q.push_back(8'h80); exp_q.push_back(8'h84);
`else
        exp_q.push_back(8'h8f); exp_q.push_back(8'h87);
`endif
        set_src(1, 4'b1111);
        step(1);
`ifdef DRIVE_MUX_SANITIZE_EN
        check("san_all", 8'(cmd_out), 8'h00);
`else
        check("san_all", 8'(cmd_out), 8'h0f);
`endif
        step(3);
        set_src(1, 4'b0111);
        step(1);
`ifdef DRIVE_MUX_SANITIZE_EN
        check("san_fb", 8'(cmd_out), 8'h04);
`else
        check("san_fb", 8'(cmd_out), 8'h07);
`endif

        // Power loss
        step(2);
        exp_q.push_back(8'h80);
        power = 1'b0;
        step(1);
        check("pwr_cmd", 8'(cmd_out), 8'h00);
        check("pwr_sw", 8'(switching), 8'h00);
        check("pwr_idx", 8'(active_idx), 8'h01);

        // Barrier bits in the frame
        step(3);
        exp_q.push_back(8'h90);
        place_barrier = 1'b1;
        step(3);
        exp_q.push_back(8'ha0);
        place_barrier = 1'b0; destroy_barrier = 1'b1;
        step(3);
        exp_q.push_back(8'h80);
        destroy_barrier = 1'b0;
        step(3);

        // Reset while a frame is pending drops it
        frame_ready = 1'b0; frame_ready_r = 1'b0;
        place_barrier = 1'b1;
        step(1);
        check("pend_v", 8'(frame_valid), 8'h01);
        check("pend_d", frame_data, 8'h90);
        rst_n = 1'b0; place_barrier = 1'b0;
        #1;
        check("rstmid_v", 8'(frame_valid), 8'h00);
        check("rstmid_d", frame_data, 8'h80);
        step(1);
        rst_n = 1'b1;

        // Periodic refresh on the second instance
        for (int i = 0; i < 20 && !frame_valid_r; i++) step(1);
        check("ref_first_v", 8'(frame_valid_r), 8'h01);
        check("ref_first_d", frame_data_r, 8'h80);
        for (int r = 0; r < 2; r++) begin
            frame_ready_r = 1'b1;
            step(1);
            frame_ready_r = 1'b0;
            check($sformatf("ref%0d_v0", r), 8'(frame_valid_r), 8'h00);
            for (int j = 1; j <= 8; j++) begin
                step(1);
                check($sformatf("ref%0d_v%0d", r, j), 8'(frame_valid_r), 8'(j == 8));
            end
            check($sformatf("ref%0d_d", r), frame_data_r, 8'h80);
        end
        check("norefresh_v", 8'(frame_valid), 8'h00);
        check("r_cmd", 8'(cmd_out_r), 8'h00);
        check("r_sw", 8'(switching_r), 8'h00);
        check("r_idx", 8'(active_idx_r), 8'h00);
        check("r_err", 8'(mode_err_r), 8'h00);
        check("queue_left", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
